// File: rtl/hs_bus_amba_axis_w2mif_rs_if.sv
// -----------------------------------------------------------------------------
// hs_bus_amba_axis_if
//   AXI-Stream bundle used by the interface-based bus fabric.
//   master modport: drives tvalid/payload/twakeup, samples tready.
//   slave modport : samples tvalid/payload/twakeup, drives tready.
// -----------------------------------------------------------------------------
interface hs_bus_amba_axis_if #(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TSTRB_WIDTH-1:0] tstrb;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   twakeup;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    output tready
  );
endinterface

// File: rtl/hs_bus_amba_axis_w2mif_rs.sv
// -----------------------------------------------------------------------------
// hs_bus_amba_axis_w2mif_rs
//   Registered wire-to-interface AXI-Stream adapter. Flat s_axis_* wires enter,
//   pass through STAGES full-throughput skid-buffer slices and leave on an
//   hs_bus_amba_axis_if master modport. STAGES=0 is a pure wire-through.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   s_axis_*         flat AXI-Stream slave side (tready registered if STAGES>0)
//   m_axis_if        hs_bus_amba_axis_if.master output
//   pkt_cnt/beat_cnt m-side packet/beat counters (only with
//                    HS_AXIS_W2MIF_RS_PKT_CNT_EN defined)
// -----------------------------------------------------------------------------
module hs_bus_amba_axis_w2mif_rs #(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int STAGES      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TSTRB_WIDTH-1:0] s_axis_tstrb,
  input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic [TID_WIDTH-1:0]   s_axis_tid,
  input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                   s_axis_twakeup,
  hs_bus_amba_axis_if.master     m_axis_if
`ifdef HS_AXIS_W2MIF_RS_PKT_CNT_EN
  ,
  output logic [31:0]            pkt_cnt,
  output logic [31:0]            beat_cnt
`endif
);

  localparam int PW = TDATA_WIDTH + TSTRB_WIDTH + TKEEP_WIDTH + 1 +
                      TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;
  typedef logic [PW-1:0] payload_t;

  payload_t s_payload;
  payload_t m_payload;
  logic     m_valid;
  logic     m_ready;
  logic     any_valid;

  // The whole beat travels as one vector so fields can never skew.
  assign s_payload = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
                      s_axis_tid, s_axis_tdest, s_axis_tuser};

  generate
    if (STAGES == 0) begin : g_wire
      always_comb begin
        m_valid       = s_axis_tvalid;
        m_payload     = s_payload;
        s_axis_tready = m_ready;
        any_valid     = 1'b0;
      end
    end else begin : g_slices
      // Link k feeds slice k; link STAGES is the m side.
      logic [STAGES:0]   link_valid;
      logic [STAGES:0]   link_ready;
      payload_t          link_data [STAGES+1];
      logic [STAGES-1:0] slice_busy;

      assign link_valid[0]      = s_axis_tvalid;
      assign link_data[0]       = s_payload;
      assign s_axis_tready      = link_ready[0];
      assign m_valid            = link_valid[STAGES];
      assign m_payload          = link_data[STAGES];
      assign link_ready[STAGES] = m_ready;
      assign any_valid          = |slice_busy;

      for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic     main_valid, skid_valid, up_ready;
        payload_t main_data, skid_data;
        logic     in_fire, main_free, skid_load;
        logic     main_valid_n, skid_valid_n;

        assign in_fire   = link_valid[k] & up_ready;
        // Main may take a new beat when empty or emptying on this edge.
        assign main_free = ~main_valid | link_ready[k+1];
        // A beat parks in skid only when main is occupied by an older beat
        // (main held, or main about to reload from skid).
        assign skid_load = in_fire & (~main_free | skid_valid);

        always_comb begin
          main_valid_n = main_free ? (skid_valid | in_fire) : 1'b1;
          skid_valid_n = skid_load | (skid_valid & ~main_free);
        end

        // NOTE: non-blocking assignments keep every slice sampling the
        // pre-edge state of its neighbours, so the chain shifts cleanly.
        always_ff @(posedge clk) begin
          if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            up_ready   <= 1'b0;
          end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            up_ready   <= ~skid_valid_n;
          end
        end

        // NOTE: payload registers carry no reset; they are ignored while the
        // matching valid bit is low, which keeps the reset net off the wide data.
        always_ff @(posedge clk) begin
          if (main_free) begin
            if (skid_valid)   main_data <= skid_data;
            else if (in_fire) main_data <= link_data[k];
          end
          if (skid_load) skid_data <= link_data[k];
        end

        assign link_ready[k]   = up_ready;
        assign link_valid[k+1] = main_valid;
        assign link_data[k+1]  = main_data;
        assign slice_busy[k]   = main_valid | skid_valid;
      end
    end
  endgenerate

  assign m_axis_if.tvalid  = m_valid;
  assign m_ready           = m_axis_if.tready;
  assign {m_axis_if.tdata, m_axis_if.tstrb, m_axis_if.tkeep, m_axis_if.tlast,
          m_axis_if.tid, m_axis_if.tdest, m_axis_if.tuser} = m_payload;
  // Wake stays asserted as long as anything is still in flight.
  assign m_axis_if.twakeup = s_axis_twakeup | any_valid;

`ifdef HS_AXIS_W2MIF_RS_PKT_CNT_EN
  logic m_fire;
  assign m_fire = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      beat_cnt <= '0;
    end else if (m_fire) begin
      beat_cnt <= beat_cnt + 32'd1;
      if (m_axis_if.tlast) pkt_cnt <= pkt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hs_bus_amba_axis_w2mif_rs.sv
// -----------------------------------------------------------------------------
// tb_hs_bus_amba_axis_w2mif_rs
//   Directed bench for the registered wire-to-interface AXIS adapter.
//   u_s2: STAGES=2, 64-bit data; u_s1: STAGES=1, 8-bit; u_s0: STAGES=0, 8-bit.
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   on the falling edge.
// -----------------------------------------------------------------------------
module tb_hs_bus_amba_axis_w2mif_rs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- u_s2 : STAGES=2, 64-bit ----------------
  logic        s2_tvalid = 1'b0, s2_tready, s2_tlast = 1'b0, s2_twakeup = 1'b0;
  logic [63:0] s2_tdata = '0;
  logic [7:0]  s2_tstrb, s2_tkeep;
  logic        s2_tid, s2_tdest, s2_tuser;
  // Side fields derived from data so field packing order is exercised.
  assign s2_tstrb = s2_tdata[7:0];
  assign s2_tkeep = ~s2_tdata[15:8];
  assign s2_tid   = s2_tdata[1];
  assign s2_tdest = s2_tdata[2];
  assign s2_tuser = s2_tdata[0];
  hs_bus_amba_axis_if #(.TDATA_WIDTH(64)) if2 ();

  // ---------------- u_s1 : STAGES=1, 8-bit ----------------
  logic       s1_tvalid = 1'b0, s1_tready, s1_tlast = 1'b0;
  logic [7:0] s1_tdata = '0;
  hs_bus_amba_axis_if #(.TDATA_WIDTH(8)) if1 ();

  // ---------------- u_s0 : STAGES=0, 8-bit ----------------
  logic       s0_tvalid = 1'b0, s0_tready, s0_tlast = 1'b0, s0_twakeup = 1'b0;
  logic [7:0] s0_tdata = '0;
  hs_bus_amba_axis_if #(.TDATA_WIDTH(8)) if0 ();

`ifdef HS_AXIS_W2MIF_RS_PKT_CNT_EN
  logic [31:0] s2_pkt, s2_beat, s1_pkt, s1_beat, s0_pkt, s0_beat;
`endif

  hs_bus_amba_axis_w2mif_rs #(.TDATA_WIDTH(64), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
    .s_axis_tdata(s2_tdata), .s_axis_tstrb(s2_tstrb), .s_axis_tkeep(s2_tkeep),
    .s_axis_tlast(s2_tlast), .s_axis_tid(s2_tid), .s_axis_tdest(s2_tdest),
    .s_axis_tuser(s2_tuser), .s_axis_twakeup(s2_twakeup),
    .m_axis_if(if2.master)
`ifdef HS_AXIS_W2MIF_RS_PKT_CNT_EN
    , .pkt_cnt(s2_pkt), .beat_cnt(s2_beat)
`endif
  );

  hs_bus_amba_axis_w2mif_rs #(.TDATA_WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
    .s_axis_tdata(s1_tdata), .s_axis_tstrb(1'b1), .s_axis_tkeep(1'b1),
    .s_axis_tlast(s1_tlast), .s_axis_tid(1'b0), .s_axis_tdest(1'b0),
    .s_axis_tuser(1'b0), .s_axis_twakeup(1'b0),
    .m_axis_if(if1.master)
`ifdef HS_AXIS_W2MIF_RS_PKT_CNT_EN
    , .pkt_cnt(s1_pkt), .beat_cnt(s1_beat)
`endif
  );

  hs_bus_amba_axis_w2mif_rs #(.TDATA_WIDTH(8), .STAGES(0)) u_s0 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s0_tvalid), .s_axis_tready(s0_tready),
    .s_axis_tdata(s0_tdata), .s_axis_tstrb(1'b1), .s_axis_tkeep(1'b1),
    .s_axis_tlast(s0_tlast), .s_axis_tid(1'b0), .s_axis_tdest(1'b0),
    .s_axis_tuser(1'b0), .s_axis_twakeup(s0_twakeup),
    .m_axis_if(if0.master)
`ifdef HS_AXIS_W2MIF_RS_PKT_CNT_EN
    , .pkt_cnt(s0_pkt), .beat_cnt(s0_beat)
`endif
  );

  // AXIS stability on u_s2: a stalled beat must stay valid and unchanged.
  logic        pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [64:0] pd = '0;
  always @(negedge clk) begin
    if (pv && !pr && !prst) begin
      checks++;
      assert (if2.tvalid && {if2.tlast, if2.tdata} == pd)
      else begin
        errors++;
        $display("FAIL axis_stable got v=%0b d=%h want v=1 d=%h", if2.tvalid,
                 {if2.tlast, if2.tdata}, pd);
      end
    end
    pv   <= if2.tvalid;
    pr   <= if2.tready;
    prst <= rst;
    pd   <= {if2.tlast, if2.tdata};
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if2.tready = 1'b0; if1.tready = 1'b0; if0.tready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({s2_tready, s1_tready, if2.tvalid, if1.tvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold got s2r=%0b s1r=%0b v2=%0b v1=%0b want all 0",
               s2_tready, s1_tready, if2.tvalid, if1.tvalid);
    end
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if ({s2_tready, s1_tready, if2.tvalid, if2.twakeup} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release got s2r=%0b s1r=%0b v2=%0b wk=%0b want 1 1 0 0",
               s2_tready, s1_tready, if2.tvalid, if2.twakeup);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int sent, got, first_acc, first_out, last_out, gaps;
    sent = 0; got = 0; first_acc = -1; first_out = -1; last_out = -1; gaps = 0;
    if2.tready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      s2_tvalid = (sent < 16);
      s2_tdata  = 64'(sent) | 64'h1234_5678_0000_0000;
      s2_tlast  = (sent == 15);
      @(negedge clk);
      if (s2_tvalid && s2_tready) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      if (if2.tvalid) begin
        if (first_out < 0) first_out = cyc;
        else if (cyc != last_out + 1) gaps++;
        last_out = cyc;
        checks++;
        if (if2.tdata !== (64'(got) | 64'h1234_5678_0000_0000) ||
            if2.tstrb !== 8'(got) || if2.tlast !== (got == 15)) begin
          errors++;
          $display("FAIL b2b_beat%0d got d=%h s=%h l=%0b want d=%h s=%h", got,
                   if2.tdata, if2.tstrb, if2.tlast,
                   64'(got) | 64'h1234_5678_0000_0000, 8'(got));
        end
        got++;
      end
      step();
    end
    s2_tvalid = 1'b0;
    checks++;
    if (got != 16 || first_acc != 0) begin
      errors++;
      $display("FAIL b2b_count got beats=%0d first_acc=%0d want 16 0", got, first_acc);
    end
    checks++;
    if (first_out != first_acc + 2) begin
      errors++;
      $display("FAIL b2b_latency got %0d want %0d", first_out, first_acc + 2);
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL b2b_gaps got %0d want 0", gaps);
    end
  endtask

  task automatic test_backpressure();
    int acc, got;
    acc = 0; got = 0;
    if1.tready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      s1_tvalid = 1'b1;
      s1_tdata  = 8'(acc);
      @(negedge clk);
      if (cyc == 2 || cyc == 9) begin
        checks++;
        if (s1_tready !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready_c%0d got %0b want 0", cyc, s1_tready);
        end
      end
      if (s1_tready) acc++;
      step();
    end
    checks++;
    if (acc != 2) begin
      errors++;
      $display("FAIL bp_accepted got %0d want 2", acc);
    end
    if1.tready = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      s1_tvalid = (acc < 6);
      s1_tdata  = 8'(acc);
      @(negedge clk);
      if (s1_tvalid && s1_tready) acc++;
      if (if1.tvalid) begin
        checks++;
        if (if1.tdata !== 8'(got)) begin
          errors++;
          $display("FAIL bp_order%0d got %h want %h", got, if1.tdata, 8'(got));
        end
        got++;
      end
      step();
    end
    s1_tvalid = 1'b0;
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL bp_release_count got %0d want 6", got);
    end
  endtask

  task automatic test_random();
    logic [64:0] q[$];
    logic [64:0] exp;
    int sent, got;
    logic acc;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 8000 && got < 1000; cyc++) begin
      if (!s2_tvalid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        s2_tvalid = 1'b1;
        s2_tdata  = {$urandom, $urandom};
        s2_tlast  = 1'($urandom_range(0, 1));
      end
      if2.tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = s2_tvalid && s2_tready;
      if (acc) begin
        q.push_back({s2_tlast, s2_tdata});
        sent++;
      end
      if (if2.tvalid && if2.tready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra got %h want nothing", {if2.tlast, if2.tdata});
        end else begin
          exp = q.pop_front();
          if ({if2.tlast, if2.tdata} !== exp) begin
            errors++;
            $display("FAIL rand_beat%0d got %h want %h", got, {if2.tlast, if2.tdata}, exp);
          end
        end
        got++;
      end
      step();
      if (acc) s2_tvalid = 1'b0;
    end
    s2_tvalid = 1'b0;
    if2.tready = 1'b1;
    checks++;
    if (got != 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL rand_total got %0d left %0d want 1000 0", got, q.size());
    end
  endtask

  task automatic test_reset_flush();
    int acc, seen;
    acc = 0; seen = 0;
    if2.tready = 1'b0;
    for (int cyc = 0; cyc < 10 && acc < 3; cyc++) begin
      s2_tvalid = 1'b1;
      s2_tdata  = 64'hA0 + 64'(acc);
      s2_tlast  = 1'b0;
      @(negedge clk);
      if (s2_tready) acc++;
      step();
    end
    s2_tvalid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (acc != 3 || if2.tvalid !== 1'b1) begin
      errors++;
      $display("FAIL flush_prefill got acc=%0d v=%0b want 3 1", acc, if2.tvalid);
    end
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if ({if2.tvalid, s2_tready} !== 2'b00) begin
      errors++;
      $display("FAIL flush_in_rst got v=%0b r=%0b want 0 0", if2.tvalid, s2_tready);
    end
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if ({if2.tvalid, s2_tready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_after_rst got v=%0b r=%0b want 0 1", if2.tvalid, s2_tready);
    end
    step();
    if2.tready = 1'b1;
    s2_tvalid  = 1'b1;
    s2_tdata   = 64'h55;
    step();
    s2_tvalid = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (if2.tvalid) begin
        checks++;
        if (if2.tdata !== 64'h55) begin
          errors++;
          $display("FAIL flush_stale got %h want 55", if2.tdata);
        end
        seen++;
      end
      step();
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL flush_count got %0d want 1", seen);
    end
  endtask

  task automatic test_twakeup();
    logic drained;
    drained = 1'b0;
    if2.tready = 1'b0;
    s2_twakeup = 1'b0;
    @(negedge clk);
    checks++;
    if (if2.twakeup !== 1'b0) begin
      errors++;
      $display("FAIL wake_idle got %0b want 0", if2.twakeup);
    end
    step();
    s2_twakeup = 1'b1;
    @(negedge clk);
    checks++;
    if (if2.twakeup !== 1'b1) begin
      errors++;
      $display("FAIL wake_comb got %0b want 1", if2.twakeup);
    end
    step();
    s2_twakeup = 1'b0;
    s2_tvalid  = 1'b1;
    s2_tdata   = 64'h77;
    step();
    s2_tvalid = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checks++;
      if (if2.twakeup !== 1'b1) begin
        errors++;
        $display("FAIL wake_inflight_c%0d got %0b want 1", cyc, if2.twakeup);
      end
      step();
    end
    if2.tready = 1'b1;
    for (int cyc = 0; cyc < 6 && !drained; cyc++) begin
      @(negedge clk);
      if (if2.tvalid) drained = 1'b1;
      step();
    end
    @(negedge clk);
    checks++;
    if (!drained || if2.twakeup !== 1'b0) begin
      errors++;
      $display("FAIL wake_drained got drained=%0b wk=%0b want 1 0", drained, if2.twakeup);
    end
    step();
  endtask

  task automatic test_passthrough();
    if0.tready = 1'b1;
    s0_tvalid  = 1'b1;
    s0_tdata   = 8'h3C;
    s0_tlast   = 1'b1;
    s0_twakeup = 1'b1;
    @(negedge clk);
    checks++;
    if ({if0.tvalid, if0.tdata, if0.tlast, s0_tready, if0.twakeup} !== {1'b1, 8'h3C, 3'b111}) begin
      errors++;
      $display("FAIL pass_fwd got v=%0b d=%h l=%0b r=%0b wk=%0b want 1 3c 1 1 1",
               if0.tvalid, if0.tdata, if0.tlast, s0_tready, if0.twakeup);
    end
    step();
    if0.tready = 1'b0;
    s0_tvalid  = 1'b0;
    s0_twakeup = 1'b0;
    @(negedge clk);
    checks++;
    if ({s0_tready, if0.tvalid, if0.twakeup} !== 3'b000) begin
      errors++;
      $display("FAIL pass_idle got r=%0b v=%0b wk=%0b want 0 0 0",
               s0_tready, if0.tvalid, if0.twakeup);
    end
    step();
  endtask

`ifdef HS_AXIS_W2MIF_RS_PKT_CNT_EN
  task automatic test_counters();
    int sent;
    sent = 0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    if2.tready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      s2_tvalid = (sent < 12);
      s2_tdata  = 64'(sent);
      s2_tlast  = (sent % 4 == 3);
      @(negedge clk);
      if (s2_tvalid && s2_tready) sent++;
      step();
    end
    s2_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (s2_beat !== 32'd12 || s2_pkt !== 32'd3) begin
      errors++;
      $display("FAIL cnt got beats=%0d pkts=%0d want 12 3", s2_beat, s2_pkt);
    end
    step();
  endtask
`endif

  initial begin
    if2.tready = 1'b0; if1.tready = 1'b0; if0.tready = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_flush();
    test_twakeup();
    test_passthrough();
`ifdef HS_AXIS_W2MIF_RS_PKT_CNT_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
